// File: rtl/ft8_sample_fifo_wb.sv
// FT8 baseband sample FIFO behind a Wishbone classic slave (DATA/STATUS/CTRL/OVFCNT).
// Optional dropped-sample counter at 0x0C is built only when FT8_OVF_CNT_EN is defined.
module ft8_sample_fifo_wb #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          DATA_W     = 12,
    parameter int          DEPTH_LOG2 = 5
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    output logic              irq_o
);
    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  thr_q, thr_d, level;
    logic              en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
    logic              ack_q, ack_d, irq_q, irq_d;
    logic [31:0]       dat_q, dat_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_sample;

    logic        hit, access, empty, full;
    logic        pop, flush, ovf_clr, ovfcnt_clr;
    logic        push_req, push_ok, overflow;
    logic [31:0] rdata, ovfcnt_rd;

    assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign access    = hit & ~ack_q;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                       (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign rd_sample = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        thr_d      = thr_q;
        pop        = 1'b0;
        flush      = 1'b0;
        ovf_clr    = 1'b0;
        ovfcnt_clr = 1'b0;
        rdata      = 32'b0;
        if (access) begin
            case (wbs_adr_i[7:0])
                8'h00: begin
                    if (!wbs_we_i && !empty) begin
                        rdata = 32'h8000_0000 | 32'(rd_sample);
                        pop   = 1'b1;
                    end
                end
                8'h04: begin
                    if (wbs_we_i) begin
                        ovf_clr = wbs_sel_i[0] & wbs_dat_i[18];
                    end else begin
                        rdata = {13'b0, ovf_q, full, empty, 7'b0, 9'(level)};
                    end
                end
                8'h08: begin
                    if (wbs_we_i) begin
                        if (wbs_sel_i[0]) begin
                            en_d     = wbs_dat_i[0];
                            irq_en_d = wbs_dat_i[1];
                            flush    = wbs_dat_i[2];
                        end
                        if (wbs_sel_i[1]) begin
                            thr_d = wbs_dat_i[8 +: PTR_W];
                        end
                    end else begin
                        rdata = (32'(thr_q) << 8) | {30'b0, irq_en_q, en_q};
                    end
                end
                8'h0C: begin
                    if (wbs_we_i) begin
                        ovfcnt_clr = wbs_sel_i[0];
                    end else begin
                        rdata = ovfcnt_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
    always_comb begin
        push_req = sample_valid_i & en_q;
        push_ok  = push_req & ~flush & (~full | pop);
        overflow = push_req & ~flush & full & ~pop;
        if (flush) begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
        ovf_d = (ovf_q & ~ovf_clr) | overflow;
        ack_d = access;
        dat_d = rdata;
        irq_d = irq_en_q & (ovf_q | ((thr_q != '0) && (level >= thr_q)));
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            thr_q    <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
            dat_q    <= 32'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            thr_q    <= thr_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
            dat_q    <= dat_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= sample_i;
        end
    end

`ifdef FT8_OVF_CNT_EN
    logic [15:0] ovfcnt_q, ovfcnt_d;

    always_comb begin
        ovfcnt_d = ovfcnt_q;
        if (ovfcnt_clr) begin
            ovfcnt_d = 16'h0;
        end else if (overflow && (ovfcnt_q != 16'hFFFF)) begin
            ovfcnt_d = ovfcnt_q + 16'h1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ovfcnt_q <= 16'h0;
        end else begin
            ovfcnt_q <= ovfcnt_d;
        end
    end

    assign ovfcnt_rd = {16'h0, ovfcnt_q};
`else
    assign ovfcnt_rd = 32'h0;
`endif

    logic unused_bits;
    assign unused_bits = ^{wbs_dat_i, wbs_sel_i, ovfcnt_clr};

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_ft8_sample_fifo_wb.sv
// Randomised bench for ft8_sample_fifo_wb against a queue-based reference model.
// Expected OVFCNT follows FT8_OVF_CNT_EN, matching the build of the design.
module tb_ft8_sample_fifo_wb;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 32;

    logic        clk, rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [11:0] sample;
    logic        sample_valid;
    logic        irq;

    ft8_sample_fifo_wb dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .sample_i(sample), .sample_valid_i(sample_valid), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: sample queue plus register contents
    logic [11:0] q[$];
    bit          m_en, m_ie, m_ovf;
    int          m_thr, m_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] statusExp();
        logic [31:0] s;
        s = 32'(q.size());
        if (q.size() == 0)     s = s | 32'h0001_0000;
        if (q.size() == DEPTH) s = s | 32'h0002_0000;
        if (m_ovf)             s = s | 32'h0004_0000;
        return s;
    endfunction

    function automatic logic [31:0] irqExp();
        return (m_ie && (m_ovf || (m_thr != 0 && q.size() >= m_thr))) ? 32'd1 : 32'd0;
    endfunction

    task automatic modelReset();
        q.delete();
        m_en = 0; m_ie = 0; m_ovf = 0; m_thr = 0; m_cnt = 0;
    endtask

    task automatic modelPush(input logic [11:0] v, input bit en);
        if (en) begin
            if (q.size() < DEPTH) q.push_back(v);
            else begin
                m_ovf = 1;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One Wishbone access, optionally with a sample push landing on the same edge as the access.
    task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input bit do_push, input logic [11:0] pv,
                                 output logic [31:0] got, output logic [31:0] exp, output bit acked);
        bit old_en;
        bit fl;
        old_en = m_en;
        fl     = 0;
        exp    = 32'h0;
        if (a[31:8] == BASE[31:8]) begin
            case (a[7:0])
                8'h00: if (!w && q.size() > 0) exp = 32'h8000_0000 | 32'(q.pop_front());
                8'h04: begin
                    if (!w) exp = statusExp();
                    else if (s[0] && d[18]) m_ovf = 0;
                end
                8'h08: begin
                    if (!w) exp = 32'(m_thr << 8) | (m_ie ? 32'd2 : 32'd0) | (m_en ? 32'd1 : 32'd0);
                    else begin
                        if (s[0]) begin
                            m_en = d[0];
                            m_ie = d[1];
                            fl   = d[2];
                        end
                        if (s[1]) m_thr = int'((d >> 8) & 32'h3F);
                    end
                end
                8'h0C: begin
`ifdef FT8_OVF_CNT_EN
                    if (!w) exp = 32'(m_cnt);
                    else if (s[0]) m_cnt = 0;
`endif
                end
                default: ;
            endcase
        end
        if (fl) q.delete();
        else if (do_push) modelPush(pv, old_en);

        stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
        if (do_push) begin
            sample = pv;
            sample_valid = 1;
        end
        acked = 0;
        got   = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            sample_valid = 0;
            if (ack) begin
                got   = rdat;
                acked = 1;
                break;
            end
        end
        stb = 0; cyc = 0; we = 0;
        idleCycles(1);
    endtask

    task automatic doAccess(input string tag, input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit do_push, input logic [11:0] pv);
        logic [31:0] got, exp;
        bit acked;
        applyStimulus(w, a, d, s, do_push, pv, got, exp, acked);
        checkOutput({tag, "_ack"}, 32'(acked), 32'd1);
        if (!w) checkOutput(tag, got, exp);
    endtask

    task automatic pushSample(input logic [11:0] v);
        sample = v;
        sample_valid = 1;
        @(posedge clk);
        #1;
        sample_valid = 0;
        modelPush(v, m_en);
    endtask

    initial begin
        logic [31:0] got, exp;
        bit acked;
        rst = 1; stb = 0; cyc = 0; we = 0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        sample = 12'h0; sample_valid = 0;
        modelReset();
        idleCycles(3);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_dat", rdat, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        rst = 0;
        idleCycles(1);
        doAccess("rst_status", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);
        doAccess("rst_ctrl",   0, BASE + 32'h8, 32'h0, 4'hF, 0, 12'h0);

        // Basic push and drain, including a read from the empty FIFO
        doAccess("ctrl_en", 1, BASE + 32'h8, 32'h1, 4'hF, 0, 12'h0);
        pushSample(12'h123);
        pushSample(12'hABC);
        doAccess("data0", 0, BASE, 32'h0, 4'hF, 0, 12'h0);
        doAccess("data1", 0, BASE, 32'h0, 4'hF, 0, 12'h0);
        doAccess("data_empty", 0, BASE, 32'h0, 4'hF, 0, 12'h0);
        doAccess("status_drained", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);

        // Overfill by 8
        for (int i = 0; i < 40; i++) pushSample(12'($urandom));
        doAccess("status_full", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);
        doAccess("ovfcnt_full", 0, BASE + 32'hC, 32'h0, 4'hF, 0, 12'h0);
        doAccess("ovf_w1c", 1, BASE + 32'h4, 32'h0004_0000, 4'hF, 0, 12'h0);
        doAccess("status_cleared", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);

        // Pop and push on the same edge while full, then flush racing a push
        doAccess("data_pop_push", 0, BASE, 32'h0, 4'hF, 1, 12'h5A5);
        doAccess("status_pop_push", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);
        doAccess("ctrl_flush", 1, BASE + 32'h8, 32'h5, 4'h1, 1, 12'h777);
        doAccess("status_flushed", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);
        doAccess("ctrl_after_flush", 0, BASE + 32'h8, 32'h0, 4'hF, 0, 12'h0);

        // Threshold interrupt with its one-cycle lag
        doAccess("ctrl_thr", 1, BASE + 32'h8, 32'h0000_0A03, 4'h3, 0, 12'h0);
        doAccess("ctrl_thr_rd", 0, BASE + 32'h8, 32'h0, 4'hF, 0, 12'h0);
        for (int i = 0; i < 9; i++) pushSample(12'($urandom));
        idleCycles(1);
        checkOutput("irq_below_thr", 32'(irq), 32'd0);
        pushSample(12'h0AA);
        checkOutput("irq_lag", 32'(irq), 32'd0);
        idleCycles(1);
        checkOutput("irq_at_thr", 32'(irq), irqExp());
        doAccess("data_thr", 0, BASE, 32'h0, 4'hF, 0, 12'h0);
        checkOutput("irq_after_pop", 32'(irq), irqExp());

        // Random mix of pushes, pops, status and counter reads against the model
        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: pushSample(12'($urandom));
                4, 5: doAccess("rnd_data", 0, BASE, 32'h0, 4'hF, 1'($urandom_range(0, 1)), 12'($urandom));
                6: doAccess("rnd_status", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);
                7: doAccess("rnd_w1c", 1, BASE + 32'h4, 32'h0004_0000,
                            ($urandom_range(0, 1) != 0) ? 4'h1 : 4'h2, 0, 12'h0);
                8: doAccess("rnd_ovfcnt", 0, BASE + 32'hC, 32'h0, 4'hF, 0, 12'h0);
                default: ;
            endcase
            idleCycles(1);
            checkOutput("rnd_irq", 32'(irq), irqExp());
        end
        doAccess("rnd_status_end", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);

        // Address decode
        applyStimulus(0, BASE + 32'h100, 32'h0, 4'hF, 0, 12'h0, got, exp, acked);
        checkOutput("miss_no_ack", 32'(acked), 32'd0);
        doAccess("unmapped_rd", 0, BASE + 32'h20, 32'h0, 4'hF, 0, 12'h0);
        doAccess("unmapped_wr", 1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 12'h0);
        doAccess("status_after_unmapped", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);

        // Reset in the middle of a back-to-back burst
        pushSample(12'h111);
        pushSample(12'h222);
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h4; sel = 4'hF;
        idleCycles(1);
        checkOutput("burst_ack1", 32'(ack), 32'd1);
        idleCycles(1);
        checkOutput("burst_gap", 32'(ack), 32'd0);
        idleCycles(1);
        checkOutput("burst_ack2", 32'(ack), 32'd1);
        rst = 1;
        #1;
        checkOutput("rst_async_ack", 32'(ack), 32'd0);
        checkOutput("rst_async_dat", rdat, 32'd0);
        stb = 0; cyc = 0;
        idleCycles(2);
        rst = 0;
        modelReset();
        idleCycles(1);
        checkOutput("rst2_irq", 32'(irq), 32'd0);
        doAccess("rst2_status", 0, BASE + 32'h4, 32'h0, 4'hF, 0, 12'h0);
        doAccess("rst2_ctrl",   0, BASE + 32'h8, 32'h0, 4'hF, 0, 12'h0);
        doAccess("rst2_ovfcnt", 0, BASE + 32'hC, 32'h0, 4'hF, 0, 12'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
